// File: rtl/led_share_sched_pkg.sv
// Shared types and constants for the LED display-sharing scheduler.
package led_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int LED_W    = 8;
    localparam int NREQ_MAX = 8;

endpackage

// File: rtl/led_share_sched_if.sv
// Source-side and LED-side signals of the display-sharing scheduler.
interface led_share_sched_if #(
    parameter int NREQ  = 4,
    parameter int NTAPS = 6
);
    import led_share_pkg::*;

    logic [NTAPS-1:0]      taps;
    logic [NREQ-1:0]       req;
    logic [LED_W*NREQ-1:0] data;
    logic [NREQ-1:0]       grant;
    logic [LED_W-1:0]      val;
    logic                  busy;

    modport master (output taps, output req, output data,
                    input grant, input val, input busy);
    modport slave  (input taps, input req, input data,
                    output grant, output val, output busy);

endinterface

// File: rtl/led_share_sched_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', with 'last' itself checked last.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    int j;

    // Scan from the farthest candidate down so the nearest one after 'last' overwrites.
    always_comb begin
        any    = |req;
        winner = last;
        j      = 0;
        for (int i = NREQ; i >= 1; i--) begin
            j = int'(last) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) winner = IDX_W'(j);
        end
    end

endmodule

// File: rtl/led_share_sched.sv
// Time-sliced round-robin owner of the 8-LED bank; dwell measured in timebase tap edges.
//  state | meaning
//  IDLE  | no owner, display shows IDLE_VAL
//  HOLD  | owner 'last_q' drives the display until release or dwell expiry
module led_share_sched
    import led_share_pkg::*;
#(
    parameter int             NREQ     = 4,
    parameter int             NTAPS    = 6,
    parameter int             TAP_SEL  = 3,
    parameter int             DWELL    = 4,
    parameter logic [LED_W-1:0] IDLE_VAL = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    led_share_sched_if.slave bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(DWELL) + 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [LED_W-1:0]   val_q, val_d;
    logic               tap_q;
    logic               tick, expire;
    logic               any;
    logic [IDX_W-1:0]   winner;
    logic [LED_W-1:0]   win_byte, own_byte;
    logic               unused_taps;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req    (bus.req),
        .last   (last_q),
        .any    (any),
        .winner (winner)
    );

    assign tick        = bus.taps[TAP_SEL] & ~tap_q;
    assign expire      = tick && (cnt_q == CNT_W'(DWELL - 1));
    assign win_byte    = bus.data[LED_W*int'(winner) +: LED_W];
    assign own_byte    = bus.data[LED_W*int'(last_q) +: LED_W];
    assign unused_taps = ^bus.taps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NREQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            val_q   <= IDLE_VAL;
            tap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            val_q   <= val_d;
            tap_q   <= bus.taps[TAP_SEL];
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                val_d   = IDLE_VAL;
                if (any) begin
                    state_d = HOLD;
                    last_d  = winner;
                    grant_d = NREQ'(1) << winner;
                    val_d   = win_byte;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                // Release wins over expiry and always leaves a one-cycle IDLE gap.
                if (!bus.req[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    val_d   = IDLE_VAL;
                    cnt_d   = '0;
                end else if (expire) begin
                    cnt_d = '0;
                    val_d = own_byte;
                    if (winner != last_q) begin
                        last_d  = winner;
                        grant_d = NREQ'(1) << winner;
                        val_d   = win_byte;
                    end
                end else begin
                    val_d = own_byte;
                    if (tick) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                val_d   = IDLE_VAL;
            end
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.val   = val_q;
    assign bus.busy  = (state_q == HOLD);

endmodule

// File: tb/tb_led_share_sched.sv
// Directed and randomized checks of led_share_sched against an owner/pointer reference model.
module tb_led_share_sched;

    localparam int         NREQ     = 4;
    localparam int         NTAPS    = 6;
    localparam int         TAP_SEL  = 3;
    localparam int         DWELL    = 4;
    localparam logic [7:0] IDLE_VAL = 8'h00;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_share_sched_if #(.NREQ(NREQ), .NTAPS(NTAPS)) bus ();

    led_share_sched #(
        .NREQ(NREQ), .NTAPS(NTAPS), .TAP_SEL(TAP_SEL),
        .DWELL(DWELL), .IDLE_VAL(IDLE_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = nobody), last grant, ticks seen in this dwell.
    int         m_owner;
    int         m_last;
    int         m_cnt;
    bit         m_tapq;
    logic [7:0] m_val;

    function automatic int pick(logic [NREQ-1:0] r, int last);
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = (last + i) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(logic [8*NREQ-1:0] d, int k);
        return d[8*k +: 8];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NREQ - 1;
        m_cnt   = 0;
        m_tapq  = 1'b0;
        m_val   = IDLE_VAL;
    endtask

    task automatic model_edge();
        bit tick;
        int w;
        tick   = bus.taps[TAP_SEL] && !m_tapq;
        m_tapq = bus.taps[TAP_SEL];
        if (m_owner < 0) begin
            w = pick(bus.req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_cnt   = 0;
                m_val   = byte_of(bus.data, w);
            end else begin
                m_val = IDLE_VAL;
            end
        end else if (!bus.req[m_owner]) begin
            m_owner = -1;
            m_cnt   = 0;
            m_val   = IDLE_VAL;
        end else if (tick && m_cnt == DWELL - 1) begin
            w = pick(bus.req, m_last);
            m_owner = w;
            m_last  = w;
            m_cnt   = 0;
            m_val   = byte_of(bus.data, w);
        end else begin
            if (tick) m_cnt++;
            m_val = byte_of(bus.data, m_owner);
        end
    endtask

    task automatic check_model(string tag);
        logic [NREQ-1:0] eg;
        eg = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(eg));
        chk({tag, "_val"},   32'(bus.val),   32'(m_val));
        chk({tag, "_busy"},  32'(bus.busy),  32'(m_owner >= 0));
    endtask

    // Inputs must already be set; computes the model for the coming edge then checks after it.
    task automatic step(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_tap(bit t);
        logic [NTAPS-1:0] tv;
        tv = NTAPS'($urandom);
        tv[TAP_SEL] = t;
        bus.taps = tv;
    endtask

    // Called just after a rising edge; asserts reset between edges.
    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.grant), 32'(0));
        chk("rst_val",   32'(bus.val),   32'(IDLE_VAL));
        chk("rst_busy",  32'(bus.busy),  32'(0));
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    logic [NREQ-1:0] seq[$];
    logic [NREQ-1:0] prev_g;

    initial begin
        rst_n    = 1'b0;
        bus.taps = '0;
        bus.req  = '0;
        bus.data = '0;
        model_reset();
        #12;
        chk("reset_grant", 32'(bus.grant), 32'(0));
        chk("reset_val",   32'(bus.val),   32'(IDLE_VAL));
        chk("reset_busy",  32'(bus.busy),  32'(0));
        rst_n = 1'b1;

        // Single source
        bus.data = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.req  = 4'b0100;
        set_tap(1'b0);
        step("single");
        chk("single_grant_c", 32'(bus.grant), 32'(4'b0100));
        chk("single_val_c",   32'(bus.val),   32'(8'hA5));
        chk("single_busy_c",  32'(bus.busy),  32'(1));
        for (int i = 0; i < 14; i++) begin
            set_tap(i[0] == 1'b0);
            step("single_hold");
        end
        chk("single_kept", 32'(bus.grant), 32'(4'b0100));

        // Rotation 0 -> 1 -> 3 -> 0
        mid_reset();
        bus.data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.req  = 4'b1011;
        prev_g   = '0;
        seq.delete();
        for (int i = 0; i < 30; i++) begin
            set_tap(i[0] == 1'b1);
            step("rot");
            if (bus.grant != prev_g) seq.push_back(bus.grant);
            prev_g = bus.grant;
        end
        chk("rot_len_ge4", 32'(seq.size() >= 4), 32'(1));
        if (seq.size() >= 4) begin
            chk("rot_0", 32'(seq[0]), 32'(4'b0001));
            chk("rot_1", 32'(seq[1]), 32'(4'b0010));
            chk("rot_2", 32'(seq[2]), 32'(4'b1000));
            chk("rot_3", 32'(seq[3]), 32'(4'b0001));
        end

        // Release gap
        mid_reset();
        bus.data = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
        bus.req  = 4'b0110;
        set_tap(1'b0);
        step("gap_grant");
        chk("gap_owner1", 32'(bus.grant), 32'(4'b0010));
        set_tap(1'b1); step("gap_hold");
        set_tap(1'b0); step("gap_hold");
        bus.req = 4'b0100;
        step("gap_drop");
        chk("gap_idle_grant", 32'(bus.grant), 32'(0));
        chk("gap_idle_val",   32'(bus.val),   32'(IDLE_VAL));
        step("gap_next");
        chk("gap_next_grant", 32'(bus.grant), 32'(4'b0100));
        chk("gap_next_val",   32'(bus.val),   32'(8'h5C));

        // Release in the same cycle as expiry
        mid_reset();
        bus.req = 4'b0011;
        set_tap(1'b0);
        step("rve_grant");
        for (int i = 0; i < 20 && m_cnt != DWELL - 1; i++) begin
            set_tap(i[0] == 1'b0);
            step("rve_tick");
        end
        set_tap(1'b0);
        step("rve_low");
        set_tap(1'b1);
        bus.req = 4'b0010;
        step("rve_drop");
        chk("rve_idle", 32'(bus.grant), 32'(0));
        step("rve_next");
        chk("rve_next", 32'(bus.grant), 32'(4'b0010));

        // Async reset while holding
        mid_reset();
        bus.req = 4'b1111;
        set_tap(1'b0);
        step("rst_regrant");
        chk("rst_first0", 32'(bus.grant), 32'(4'b0001));

        // Tap held high counts once
        mid_reset();
        bus.req = 4'b0011;
        set_tap(1'b0);
        step("tick_grant");
        for (int i = 0; i < 10; i++) begin
            set_tap(1'b1);
            step("tick_high");
        end
        chk("tick_held", 32'(bus.grant), 32'(4'b0001));
        for (int i = 0; i < 2; i++) begin
            set_tap(1'b0); step("tick_tog");
            set_tap(1'b1); step("tick_tog");
        end
        chk("tick_3", 32'(bus.grant), 32'(4'b0001));
        set_tap(1'b0); step("tick_tog");
        set_tap(1'b1); step("tick_4");
        chk("tick_rot", 32'(bus.grant), 32'(4'b0010));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) mid_reset();
            if ($urandom_range(0, 3) == 0) bus.req = NREQ'($urandom_range(0, 15));
            bus.data = $urandom;
            set_tap($urandom_range(0, 1) == 1);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_share_sched.md
# led_share_sched

Round-robin scheduler that shares the 8-LED display bank among up to NREQ requesting sources (stepped counter, DIP value, status words). It time-slices ownership using a dwell period counted in timebase tap edges, and drives the winning source's byte into `led8`. It sits between the `timebase` and data producers on one side and `led8` on the other.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `NTAPS`, 6: width of the `taps` bus from `timebase`.
- `TAP_SEL`, 3: index of the tap whose rising edge is one dwell tick; must be < NTAPS.
- `DWELL`, 4: ticks a grant is held before rotation when others wait; must be ≥ 1.
- `IDLE_VAL`, 8'h00: value shown when no grant is active.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `taps`  in  NTAPS  timebase tap bits.
- `req`  in  NREQ  per-source request level; held high while the source wants the display.
- `data`  in  8*NREQ  per-source display byte; source i occupies bits [8i+7:8i].
- `grant`  out  NREQ  one-hot (or zero) registered grant.
- `val`  out  8  registered display byte to `led8`.
- `busy`  out  1  high while any grant is active.

## Operation
- Tick detection:
  - Register `taps[TAP_SEL]` into `tap_q`.
  - `tick` = `taps[TAP_SEL] & ~tap_q`, which is a one-cycle strobe.
- Round-robin pointer `last`:
  - Holds the index of the most recent grant.
  - The winner is the first requesting index scanning `last+1`, `last+2`, …, wrapping modulo NREQ.
  - `last` itself is considered last.
- State IDLE:
  - `grant`=0, `busy`=0, `val`=IDLE_VAL.
  - If any `req`, the next edge sets `grant` to the winner, `last` to the winner, and `val` to the winner's `data`, clears `dwell_cnt`, and enters HOLD.
- State HOLD (owner k):
  - Every cycle, `val` ← `data[k]`.
  - On `tick`, `dwell_cnt` increments.
- Release:
  - If `req[k]`=0, the next edge clears `grant`, sets `val` ← IDLE_VAL, and enters IDLE.
  - This gives a mandatory one-cycle gap before any new grant.
- Expiry: `tick` while `dwell_cnt`=DWELL-1.
  - If any other req is pending: switch directly (no gap) on that edge. Set `grant`/`last` to the winner, `val` ← `data[winner]`, and clear `dwell_cnt`.
  - If no other req is pending: keep k and clear `dwell_cnt`.
- Simultaneous events:
  - Release has priority over expiry in the same cycle.
  - Requests arriving during HOLD only take effect at expiry or release.
- `dwell_cnt` width: `$clog2(DWELL)+1`. It never exceeds DWELL-1 and does not wrap.
- `grant` is never multi-hot.

## Timing
- Reset values (asynchronous assertion, applied immediately):
  - `grant`=0, `val`=IDLE_VAL, `busy`=0.
  - state=IDLE, `last`=NREQ-1 (so index 0 wins first).
  - `dwell_cnt`=0, `tap_q`=0.
- Reset release: a `taps[TAP_SEL]` that is already high counts as a tick on the first cycle.
- Request to grant: `req` sampled high in IDLE at edge n gives `grant`/`val` valid after edge n. This is one-cycle latency.
- Data to `val` in HOLD: one-cycle latency.
- Release to next grant: the edge after the drop clears `grant`. The earliest new grant is at the following edge.
- Rotation: occurs on the edge where the DWELL-th `tick` is sampled.
- Reset mid-HOLD: outputs return to reset values immediately. Arbitration restarts from index 0.

## Structure
- Shared package `led_share_pkg`:
  - state enum (IDLE, HOLD);
  - `LED_W`=8;
  - `NREQ_MAX`=8.
- One sub-module, `rr_pick`:
  - combinational round-robin picker;
  - inputs: `req`, `last`;
  - outputs: `any`, `winner` index.
  - `led_share_sched` holds the state, registers, tick detection and dwell counter.

## Test plan
- Single source:
  - Stimulus: reset, then `req`=4'b0100, `data[2]`=8'hA5.
  - Required: `grant`=4'b0100 and `val`=8'hA5 one cycle later; `busy`=1. Across ticks the grant stays and `dwell_cnt` recycles.
- Rotation:
  - Stimulus: `req`=4'b1011 held, DWELL=4.
  - Required: grants in order 0→1→3→0. Each switch happens on the 4th tick with no IDLE gap; `val` follows each owner's byte.
- Release gap:
  - Stimulus: owner 1 drops `req` mid-dwell while `req[2]`=1.
  - Required: next edge gives `grant`=0 and `val`=IDLE_VAL; the edge after gives `grant`=4'b0100.
- Release vs expiry:
  - Stimulus: owner drops `req` in the same cycle as the DWELL-th tick, with others pending.
  - Required: IDLE for one cycle, no direct switch.
- Async reset mid-HOLD:
  - Stimulus: assert `rst_n`=0 between edges.
  - Required: `grant`=0 and `val`=IDLE_VAL immediately. After release, with `req`=4'b1111, the first grant is 4'b0001.
- Tick edge:
  - Stimulus: `taps[TAP_SEL]` held high for 10 cycles.
  - Required: exactly one `dwell_cnt` increment.
